// File: rtl/mano_io_device.sv
// rtl/mano_io_device.sv - Mano-style character I/O device with receive FIFO and handshaked transmit register
//
// Ports:
//   CLK, RST_N        clock (rising edge) and asynchronous active-low reset
//   rx_valid/rx_data  host byte offered to the input channel; rx_ready = FIFO not full
//   INPR, FGI         input register and input flag seen by the CPU
//   cpu_inp           CPU INP pulse: acknowledges INPR by clearing FGI
//   cpu_out, cpu_ac   CPU OUT pulse and AC value loaded into OUTR
//   OUTR, FGO         output register and output flag (1 = device ready for a byte)
//   tx_valid/tx_data  OUTR offered to the host; tx_ready completes the transfer
//   cpu_ion, cpu_iof  set/clear interrupt enable (clear wins)
//   IEN, intr_req     interrupt enable and request (IEN & (FGI | FGO))
//   out_err           sticky: OUT issued while the output channel was busy
module mano_io_device #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       rx_ready,
    output logic [7:0] INPR,
    output logic       FGI,
    input  logic       cpu_inp,
    input  logic       cpu_out,
    input  logic [7:0] cpu_ac,
    output logic [7:0] OUTR,
    output logic       FGO,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    input  logic       cpu_ion,
    input  logic       cpu_iof,
    output logic       IEN,
    output logic       intr_req,
    output logic       out_err
);

    localparam int AW = $clog2(FIFO_DEPTH);

    // ---------------- input channel ----------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    assign rx_ready = (count < (AW+1)'(FIFO_DEPTH));
    assign push     = rx_valid & rx_ready;
    // Reload uses the registered FGI, so a cpu_inp clear always leaves a
    // one-cycle FGI=0 gap before the next byte appears.
    assign pop      = ~FGI & (count != '0);

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            INPR   <= 8'h00;
            FGI    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                INPR   <= mem[rd_ptr];
                FGI    <= 1'b1;
            end else if (cpu_inp && FGI) begin
                FGI <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // ---------------- output channel ----------------
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } out_state_t;

    out_state_t state;
    out_state_t next_state;
    logic       outr_load;
    logic       err_set;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        outr_load  = 1'b0;
        err_set    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cpu_out) begin
                    outr_load  = 1'b1;
                    next_state = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // OUT while busy is dropped; OUTR must stay stable for the host.
                if (cpu_out) begin
                    err_set = 1'b1;
                end
                if (tx_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OUTR    <= 8'h00;
            out_err <= 1'b0;
        end else begin
            if (outr_load) begin
                OUTR <= cpu_ac;
            end
            if (err_set) begin
                out_err <= 1'b1;
            end
        end
    end

    assign FGO      = (state == ST_IDLE);
    assign tx_valid = (state == ST_BUSY);
    assign tx_data  = OUTR;

    // ---------------- interrupts ----------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            IEN <= 1'b0;
        end else if (cpu_iof) begin
            IEN <= 1'b0;
        end else if (cpu_ion) begin
            IEN <= 1'b1;
        end
    end

    assign intr_req = IEN & (FGI | FGO);

endmodule

// File: tb/tb_mano_io_device.sv
// tb/tb_mano_io_device.sv - directed self-checking bench for mano_io_device
`timescale 1ns/1ps
module tb_mano_io_device;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic [7:0] INPR;
    logic       FGI;
    logic       cpu_inp;
    logic       cpu_out;
    logic [7:0] cpu_ac;
    logic [7:0] OUTR;
    logic       FGO;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       cpu_ion;
    logic       cpu_iof;
    logic       IEN;
    logic       intr_req;
    logic       out_err;

    int checks = 0;
    int errors = 0;

    mano_io_device #(.FIFO_DEPTH(4)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .INPR     (INPR),
        .FGI      (FGI),
        .cpu_inp  (cpu_inp),
        .cpu_out  (cpu_out),
        .cpu_ac   (cpu_ac),
        .OUTR     (OUTR),
        .FGO      (FGO),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .cpu_ion  (cpu_ion),
        .cpu_iof  (cpu_iof),
        .IEN      (IEN),
        .intr_req (intr_req),
        .out_err  (out_err)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        RST_N = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; cpu_inp = 1'b0;
        cpu_out = 1'b0; cpu_ac = 8'h00; tx_ready = 1'b0; cpu_ion = 1'b0; cpu_iof = 1'b0;
        #1;
        check("rst_rx_ready", {7'd0, rx_ready}, 8'h01);
        check("rst_fgi",      {7'd0, FGI},      8'h00);
        check("rst_fgo",      {7'd0, FGO},      8'h01);
        check("rst_tx_valid", {7'd0, tx_valid}, 8'h00);
        check("rst_inpr",     INPR,             8'h00);
        check("rst_outr",     OUTR,             8'h00);
        check("rst_ien",      {7'd0, IEN},      8'h00);
        check("rst_intr",     {7'd0, intr_req}, 8'h00);
        check("rst_out_err",  {7'd0, out_err},  8'h00);
        step(); step();
        RST_N = 1'b1;

        // basic input: one-cycle latency from push to INPR/FGI
        rx_valid = 1'b1; rx_data = 8'h5A;
        step();
        rx_valid = 1'b0;
        check("in_fgi_push_edge", {7'd0, FGI}, 8'h00);
        step();
        check("in_inpr", INPR, 8'h5A);
        check("in_fgi",  {7'd0, FGI}, 8'h01);
        cpu_inp = 1'b1;
        step();
        cpu_inp = 1'b0;
        check("in_fgi_clr",   {7'd0, FGI}, 8'h00);
        check("in_inpr_hold", INPR, 8'h5A);
        step();
        check("in_fgi_empty", {7'd0, FGI}, 8'h00);

        // FIFO full: 0x01 goes to INPR, 0x02..0x05 fill the FIFO
        for (int i = 1; i <= 5; i++) begin
            rx_valid = 1'b1; rx_data = 8'(i);
            step();
        end
        check("full_inpr",     INPR, 8'h01);
        check("full_rx_ready", {7'd0, rx_ready}, 8'h00);
        rx_data = 8'h06;
        step();
        rx_valid = 1'b0;
        check("full_refuse_ready", {7'd0, rx_ready}, 8'h00);
        check("full_inpr_hold",    INPR, 8'h01);
        for (int i = 2; i <= 5; i++) begin
            cpu_inp = 1'b1;
            step();
            cpu_inp = 1'b0;
            check("drain_gap", {7'd0, FGI}, 8'h00);
            step();
            check("drain_inpr", INPR, 8'(i));
            check("drain_fgi",  {7'd0, FGI}, 8'h01);
        end
        check("drain_rx_ready", {7'd0, rx_ready}, 8'h01);
        cpu_inp = 1'b1;
        step();
        cpu_inp = 1'b0;
        step();
        check("drain_no_byte6", {7'd0, FGI}, 8'h00);
        check("drain_inpr_last", INPR, 8'h05);
        // cpu_inp with FGI=0 is ignored
        cpu_inp = 1'b1;
        step();
        cpu_inp = 1'b0;
        check("inp_ignored_inpr", INPR, 8'h05);
        check("inp_ignored_fgi",  {7'd0, FGI}, 8'h00);

        // output handshake
        cpu_out = 1'b1; cpu_ac = 8'hC3;
        step();
        cpu_out = 1'b0; cpu_ac = 8'h00;
        check("out_outr",     OUTR, 8'hC3);
        check("out_fgo",      {7'd0, FGO}, 8'h00);
        check("out_tx_valid", {7'd0, tx_valid}, 8'h01);
        for (int i = 0; i < 3; i++) begin
            step();
            check("out_hold_data",  tx_data, 8'hC3);
            check("out_hold_valid", {7'd0, tx_valid}, 8'h01);
        end
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        check("out_done_fgo",   {7'd0, FGO}, 8'h01);
        check("out_done_valid", {7'd0, tx_valid}, 8'h00);

        // out error: OUT while busy
        cpu_out = 1'b1; cpu_ac = 8'h11;
        step();
        check("err_before", {7'd0, out_err}, 8'h00);
        cpu_ac = 8'h22;
        step();
        cpu_out = 1'b0;
        check("err_outr", OUTR, 8'h11);
        check("err_flag", {7'd0, out_err}, 8'h01);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        check("err_sticky", {7'd0, out_err}, 8'h01);
        check("err_fgo",    {7'd0, FGO}, 8'h01);

        // interrupts
        cpu_ion = 1'b1;
        step();
        cpu_ion = 1'b0;
        check("ion_ien",  {7'd0, IEN}, 8'h01);
        check("ion_intr", {7'd0, intr_req}, 8'h01);
        cpu_ion = 1'b1; cpu_iof = 1'b1;
        step();
        cpu_ion = 1'b0; cpu_iof = 1'b0;
        check("iof_ien",  {7'd0, IEN}, 8'h00);
        check("iof_intr", {7'd0, intr_req}, 8'h00);

        // reset mid-transfer: A1 into INPR, A2..A4 in FIFO, tx pending
        rx_valid = 1'b1; rx_data = 8'hA1; cpu_out = 1'b1; cpu_ac = 8'h77;
        step();
        cpu_out = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            rx_data = 8'hA0 + 8'(i);
            step();
        end
        rx_valid = 1'b0;
        check("pre_rst_inpr",  INPR, 8'hA1);
        check("pre_rst_txv",   {7'd0, tx_valid}, 8'h01);
        #2;
        RST_N = 1'b0;
        #1;
        check("arst_fgi",      {7'd0, FGI}, 8'h00);
        check("arst_fgo",      {7'd0, FGO}, 8'h01);
        check("arst_tx_valid", {7'd0, tx_valid}, 8'h00);
        check("arst_rx_ready", {7'd0, rx_ready}, 8'h01);
        check("arst_inpr",     INPR, 8'h00);
        check("arst_outr",     OUTR, 8'h00);
        step();
        #2;
        RST_N = 1'b1;
        step(); step();
        check("post_rst_fgi",  {7'd0, FGI}, 8'h00);
        check("post_rst_txv",  {7'd0, tx_valid}, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
